// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry and writer state encoding, used by both the
// write side and the VGA pixel printer so the two agree on the RAM window.
package fb_pkg;

  localparam int FB_IMG_W     = 300;
  localparam int FB_IMG_H     = 300;
  localparam int FB_BASE_ADDR = 324;
  localparam int FB_PIXELS    = FB_IMG_W * FB_IMG_H;
  localparam int FB_ADDR_W    = 17;
  localparam int FB_DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } fb_state_t;

endpackage

// File: rtl/frame_buffer_writer.sv
// Write side of the grayscale frame buffer: loads a raster-order pixel stream
// or fills the frame with a constant, through a registered RAM write port.
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter int IMG_W     = FB_IMG_W,
  parameter int IMG_H     = FB_IMG_H,
  parameter int BASE_ADDR = FB_BASE_ADDR,
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              we,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int PIXELS = IMG_W * IMG_H;
  localparam int CNT_W  = $clog2(PIXELS);

  // The last pixel of the window must still be addressable by the RAM.
  generate
    if ((BASE_ADDR + PIXELS - 1) >= (1 << ADDR_W)) begin : g_addr_check
      $error("frame_buffer_writer: BASE_ADDR+IMG_W*IMG_H-1 does not fit in ADDR_W bits");
    end
  endgenerate

  fb_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_fill;
  logic              r_we;
  logic [ADDR_W-1:0] r_wr_address;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  logic              w_beat;
  logic              w_final;
  logic [ADDR_W-1:0] w_addr;

  assign s_ready = (r_state == LOAD);
  assign w_beat  = s_valid & s_ready;
  assign w_final = (r_cnt == CNT_W'(PIXELS - 1));
  assign w_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(r_cnt);

  assign we         = r_we;
  assign wr_address = r_wr_address;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

  // Write port is registered, so the final write and the done pulse land together in DONE.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_fill       <= '0;
      r_we         <= 1'b0;
      r_wr_address <= ADDR_W'(BASE_ADDR);
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_error <= 1'b0;
          end else if (clear) begin
            r_state <= CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_fill  <= fill_value;
            r_error <= 1'b0;
          end
        end
        LOAD: begin
          if (w_beat) begin
            r_we         <= 1'b1;
            r_wr_address <= w_addr;
            r_wr_data    <= s_data;
            r_cnt        <= r_cnt + CNT_W'(1);
            // A frame ends on the last pixel or an early s_last; any disagreement is a framing error.
            if (w_final || s_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              if (w_final != s_last) begin
                r_error <= 1'b1;
              end
            end
          end
        end
        CLEAR: begin
          r_we         <= 1'b1;
          r_wr_address <= w_addr;
          r_wr_data    <= r_fill;
          r_cnt        <= r_cnt + CNT_W'(1);
          if (w_final) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Scoreboard bench for frame_buffer_writer on a reduced 40x25 frame at the
// default base address, so a full frame ends at address 1323.
module tb_frame_buffer_writer;

  localparam int W    = 40;
  localparam int H    = 25;
  localparam int N    = W * H;
  localparam int BASE = 324;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    logic        done;
  } exp_t;

  logic        vga_clk;
  logic        rst;
  logic        start;
  logic        clear;
  logic [7:0]  fill_value;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        we;
  logic [16:0] wr_address;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        error;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  frame_buffer_writer #(
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .vga_clk    (vga_clk),
    .rst        (rst),
    .start      (start),
    .clear      (clear),
    .fill_value (fill_value),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .we         (we),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Pops one expected write per we; done must never appear without a write.
  always @(negedge vga_clk) begin
    exp_t e;
    if (!rst) begin
      checks++;
      if (we) begin
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpectedWrite addr=%0d data=%02h done=%0b", wr_address, wr_data, done);
        end else begin
          e = expQ.pop_front();
          if (wr_address !== e.addr || wr_data !== e.data || done !== e.done) begin
            failures++;
            $display("[TB] FAIL write got addr=%0d data=%02h done=%0b expected addr=%0d data=%02h done=%0b",
                     wr_address, wr_data, done, e.addr, e.data, e.done);
          end
        end
      end else if (done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL doneWithoutWrite got done=%0b expected 0", done);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(negedge vga_clk);
      #1;
      n++;
    end
    checkOutput({name, "_drain"}, expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic pushWrite(input int idx, input logic [7:0] data, input logic isDone);
    exp_t e;
    e.addr = 17'(BASE + idx);
    e.data = data;
    e.done = isDone;
    expQ.push_back(e);
  endtask

  // Frame end: DONE state visible now, idle one cycle later.
  task automatic checkFrameEnd(input string name, input logic expErr);
    checkOutput({name, "_busyAtDone"}, busy, 0);
    checkOutput({name, "_readyAtDone"}, s_ready, 0);
    checkOutput({name, "_error"}, error, expErr);
    @(negedge vga_clk);
    #1;
    checkOutput({name, "_doneFalls"}, done, 0);
    checkOutput({name, "_errorHeld"}, error, expErr);
  endtask

  task automatic applyStimulus(input string name, input int gapPct, input int truncAt,
                               input bit markLast, input bit poke);
    int   beats;
    logic [7:0] px;
    beats = (truncAt >= 0) ? truncAt + 1 : N;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput({name, "_errorCleared"}, error, 0);
    for (int i = 0; i < beats; i++) begin
      while (int'($urandom_range(99)) < gapPct) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        stepCycle();
      end
      if (i == 1) begin
        checkOutput({name, "_readyInLoad"}, s_ready, 1);
        checkOutput({name, "_busyInLoad"}, busy, 1);
      end
      if (poke && i == N / 2) begin
        start      = 1'b1;
        clear      = 1'b1;
        fill_value = 8'h3C;
      end
      px      = i[7:0];
      s_valid = 1'b1;
      s_data  = px;
      s_last  = (i == truncAt) || (markLast && i == N - 1);
      pushWrite(i, px, i == beats - 1);
      stepCycle();
      start = 1'b0;
      clear = 1'b0;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    waitDrain(name, 20);
    checkFrameEnd(name, (truncAt >= 0) || !markLast);
  endtask

  task automatic runClear(input logic [7:0] fill);
    int n = 0;
    int t = 0;
    fill_value = fill;
    clear      = 1'b1;
    stepCycle();
    clear      = 1'b0;
    fill_value = 8'h00;
    for (int i = 0; i < N; i++) pushWrite(i, fill, i == N - 1);
    while (!we && t < 10) begin
      @(negedge vga_clk);
      t++;
    end
    while (we && n < N + 10) begin
      n++;
      start = (n == 300);
      @(negedge vga_clk);
    end
    start = 1'b0;
    checkOutput("clear_consecutiveWe", n, N);
    checkOutput("clear_drain", expQ.size(), 0);
    expQ.delete();
    #1;
    checkOutput("clear_doneFalls", done, 0);
    checkOutput("clear_busyAfter", busy, 0);
    checkOutput("clear_error", error, 0);
  endtask

  task automatic runResetMidFrame();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      s_last  = 1'b0;
      pushWrite(i, 8'(i), 1'b0);
      stepCycle();
    end
    s_valid = 1'b0;
    @(negedge vga_clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstMid_we", we, 0);
    checkOutput("rstMid_ready", s_ready, 0);
    checkOutput("rstMid_busy", busy, 0);
    checkOutput("rstMid_done", done, 0);
    checkOutput("rstMid_addr", wr_address, BASE);
    checkOutput("rstMid_queue", expQ.size(), 0);
    expQ.delete();
    stepCycle();
    checkOutput("rstMid_addrHeld", wr_address, BASE);
    rst = 1'b0;
    repeat (3) stepCycle();
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    clear      = 1'b0;
    fill_value = 8'h00;
    s_valid    = 1'b0;
    s_data     = 8'h00;
    s_last     = 1'b0;
    repeat (3) stepCycle();
    rst = 1'b0;
    repeat (10) stepCycle();
    checkOutput("reset_we", we, 0);
    checkOutput("reset_ready", s_ready, 0);
    checkOutput("reset_addr", wr_address, BASE);
    checkOutput("reset_data", wr_data, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_error", error, 0);

    $display("[TB] full stream, no gaps");
    applyStimulus("full", 0, -1, 1'b1, 1'b0);
    $display("[TB] truncated frame, s_last on beat 500");
    applyStimulus("trunc", 0, 500, 1'b1, 1'b0);
    $display("[TB] full stream with valid gaps");
    applyStimulus("gaps", 30, -1, 1'b1, 1'b0);
    $display("[TB] full stream without s_last on final beat");
    applyStimulus("noLast", 0, -1, 1'b0, 1'b0);
    $display("[TB] clear with A5");
    runClear(8'hA5);
    $display("[TB] reset in the middle of a frame");
    runResetMidFrame();
    $display("[TB] restart after reset, start/clear poked while busy");
    applyStimulus("restart", 10, -1, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
